// File: rtl/i2c_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Shared state, phase and direction constants for the I2C master engine.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_START   = 4'd1;
  localparam logic [3:0] ST_TX      = 4'd2;
  localparam logic [3:0] ST_ACK_RX  = 4'd3;
  localparam logic [3:0] ST_RESTART = 4'd4;
  localparam logic [3:0] ST_RX      = 4'd5;
  localparam logic [3:0] ST_ACK_TX  = 4'd6;
  localparam logic [3:0] ST_STOP    = 4'd7;
  localparam logic [3:0] ST_DONE    = 4'd8;

  // Byte slot within a command: what the master is sending or receiving.
  localparam logic [2:0] PH_ADDR_W = 3'd0;
  localparam logic [2:0] PH_REG    = 3'd1;
  localparam logic [2:0] PH_DATA   = 3'd2;
  localparam logic [2:0] PH_ADDR_R = 3'd3;
  localparam logic [2:0] PH_RX     = 3'd4;

  localparam logic I2C_WR = 1'b0;
  localparam logic I2C_RD = 1'b1;

  function automatic logic [7:0] addr_byte(input logic [6:0] addr, input logic dir);
    return {addr, dir};
  endfunction

endpackage

`default_nettype wire

// File: rtl/i2c_byte_shifter.sv
// ============================================================================
// Module : i2c_byte_shifter
// Parallel-load MSB-first shift register with bit counter for one I2C byte.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_byte_shifter
  import i2c_pkg::*;
#(
  parameter int W = I2C_BYTE_W
) (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift,
  input  logic         shift_in,
  output logic [W-1:0] data,
  output logic         msb,
  output logic         bit_last
);

  localparam int CW = $clog2(W + 1);

  logic [CW-1:0] bit_cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      data    <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      data    <= load_data;
      bit_cnt <= '0;
    end else if (shift) begin
      data    <= {data[W-2:0], shift_in};
      bit_cnt <= bit_last ? '0 : bit_cnt + 1'b1;
    end
  end

  assign msb      = data[W-1];
  assign bit_last = (bit_cnt == CW'(W - 1));

endmodule

`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
// ============================================================================
// Module : i2c_master_ctrl
// Single-command I2C master (register write or register read) driven by the
// divided SCL reference and mid-low SDA strobe from clk_divider.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int NACK_ABORT = 1,
  parameter int BYTE_W     = I2C_BYTE_W
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       i2c_clk_in,
  input  logic       sda_en_in,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] slave_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  logic [3:0] state;
  logic [2:0] phase;
  logic       clk_q;
  logic       gate;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [7:0] reg_q;
  logic [7:0] wdata_q;

  logic        scl_rise;
  logic        scl_fall;
  logic        abort;
  logic        sh_load;
  logic [7:0]  sh_load_data;
  logic        sh_shift;
  logic [7:0]  sh_data;
  logic        sh_msb;
  logic        sh_last;

  assign scl_rise = i2c_clk_in & ~clk_q;
  assign scl_fall = ~i2c_clk_in & clk_q;
  assign abort    = scl_rise & sda_i & (NACK_ABORT != 0);
  assign scl_o    = gate ? i2c_clk_in : 1'b1;

  // The next byte is loaded on the same SCL rise that closes the ACK slot.
  always_comb begin
    sh_load      = 1'b0;
    sh_load_data = addr_byte(slave_addr, I2C_WR);
    sh_shift     = 1'b0;
    case (state)
      ST_IDLE: sh_load = start;
      ST_TX, ST_RX: sh_shift = scl_rise;
      ST_ACK_RX: begin
        if (scl_rise && !abort) begin
          if (phase == PH_ADDR_W) begin
            sh_load      = 1'b1;
            sh_load_data = reg_q;
          end else if (phase == PH_REG) begin
            sh_load      = 1'b1;
            sh_load_data = (rw_q == I2C_RD) ? addr_byte(addr_q, I2C_RD) : wdata_q;
          end
        end
      end
      default: ;
    endcase
  end

  i2c_byte_shifter #(
    .W (BYTE_W)
  ) u_shifter (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .shift_in  (sda_i),
    .data      (sh_data),
    .msb       (sh_msb),
    .bit_last  (sh_last)
  );

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      phase   <= PH_ADDR_W;
      clk_q   <= 1'b0;
      gate    <= 1'b0;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= 8'h00;
      rw_q    <= 1'b0;
      addr_q  <= 7'h00;
      reg_q   <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      clk_q <= i2c_clk_in;
      done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rw_q    <= rw;
            addr_q  <= slave_addr;
            reg_q   <= reg_addr;
            wdata_q <= wdata;
            busy    <= 1'b1;
            ack_err <= 1'b0;
            phase   <= PH_ADDR_W;
            state   <= ST_START;
          end
        end
        // SCL is held high; sda_oe doubles as the "START already driven" flag.
        ST_START: begin
          if (!sda_oe) begin
            if (sda_en_in) sda_oe <= 1'b1;
          end else if (scl_fall) begin
            gate  <= 1'b1;
            state <= ST_TX;
          end
        end
        ST_TX: begin
          if (sda_en_in) sda_oe <= ~sh_msb;
          if (scl_rise && sh_last) state <= ST_ACK_RX;
        end
        ST_ACK_RX: begin
          if (sda_en_in) begin
            sda_oe <= 1'b0;
          end else if (scl_rise) begin
            if (sda_i) ack_err <= 1'b1;
            if (abort) begin
              state <= ST_STOP;
            end else begin
              case (phase)
                PH_ADDR_W: begin
                  phase <= PH_REG;
                  state <= ST_TX;
                end
                PH_REG: begin
                  phase <= PH_DATA;
                  state <= (rw_q == I2C_RD) ? ST_RESTART : ST_TX;
                end
                PH_ADDR_R: begin
                  phase <= PH_RX;
                  state <= ST_RX;
                end
                default: state <= ST_STOP;
              endcase
            end
          end
        end
        ST_RESTART: begin
          if (sda_en_in) begin
            sda_oe <= 1'b0;
          end else if (scl_rise) begin
            gate  <= 1'b0;
            phase <= PH_ADDR_R;
            state <= ST_START;
          end
        end
        ST_RX: begin
          if (sda_en_in) sda_oe <= 1'b0;
          if (scl_rise && sh_last) begin
            rdata <= {sh_data[BYTE_W-2:0], sda_i};
            state <= ST_ACK_TX;
          end
        end
        ST_ACK_TX: begin
          if (sda_en_in) begin
            sda_oe <= 1'b0;
          end else if (scl_rise) begin
            state <= ST_STOP;
          end
        end
        // Gated phase pulls SDA low and parks SCL high; ungated phase releases SDA.
        ST_STOP: begin
          if (gate) begin
            if (sda_en_in) begin
              sda_oe <= 1'b1;
            end else if (scl_rise && sda_oe) begin
              gate <= 1'b0;
            end
          end else if (sda_en_in) begin
            sda_oe <= 1'b0;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
// ============================================================================
// Module : tb_i2c_master_ctrl
// Bench for i2c_master_ctrl: divider model, bus monitor with slave, directed
// and random commands compared against an event-level transaction model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_i2c_master_ctrl;

  localparam logic [6:0] SLV  = 7'h29;
  localparam int         S_EV = 1000;
  localparam int         P_EV = 2000;

  logic       clk_in     = 1'b0;
  logic       rst_n      = 1'b0;
  logic       i2c_clk_in = 1'b0;
  logic       sda_en_in  = 1'b0;
  logic       start      = 1'b0;
  logic       rw         = 1'b0;
  logic [6:0] slave_addr = 7'h00;
  logic [7:0] reg_addr   = 8'h00;
  logic [7:0] wdata      = 8'h00;
  logic       sda_i;
  logic       scl_o;
  logic       sda_oe;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic [7:0] rdata;

  logic       slave_pull = 1'b0;
  logic       sda_line;
  assign sda_line = ~sda_oe & ~slave_pull;
  assign sda_i    = sda_line;

  int errors   = 0;
  int checks   = 0;
  int half     = 4;
  int div_cnt  = 0;
  int done_cnt = 0;
  int mon_log[$];
  int exp_q[$];
  logic [7:0] slv_rval = 8'h00;
  logic [7:0] rdata_m  = 8'h00;

  i2c_master_ctrl #(.NACK_ABORT(1), .BYTE_W(8)) dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .i2c_clk_in (i2c_clk_in),
    .sda_en_in  (sda_en_in),
    .start      (start),
    .rw         (rw),
    .slave_addr (slave_addr),
    .reg_addr   (reg_addr),
    .wdata      (wdata),
    .sda_i      (sda_i),
    .scl_o      (scl_o),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .done       (done),
    .ack_err    (ack_err),
    .rdata      (rdata)
  );

  always #5 clk_in = ~clk_in;

  // clk_divider stand-in: SCL half-period of `half` cycles, strobe mid low phase.
  initial forever begin
    @(negedge clk_in);
    sda_en_in = 1'b0;
    if (div_cnt >= half - 1) begin
      div_cnt    = 0;
      i2c_clk_in = ~i2c_clk_in;
    end else begin
      div_cnt++;
    end
    if (!i2c_clk_in && div_cnt == half / 2) sda_en_in = 1'b1;
  end

  logic       scl_p = 1'b1, sda_p = 1'b1, i2c_p = 1'b0, sda_now;
  int         cnt = 0, bidx = 0;
  logic [7:0] sh = 8'h00;
  bit         tx_mode = 0, rd_pend = 0;

  // Bus monitor and slave at 0x29: logs START/STOP and each byte with its ACK bit.
  initial forever begin
    @(posedge clk_in);
    sda_now = sda_line;
    if (done === 1'b1) done_cnt++;
    if (sda_en_in) begin
      checks++;
      assert (!(i2c_clk_in && !i2c_p)) else begin
        errors++;
        $error("FAIL strobe_vs_rise: strobe coincided with SCL rise, required separation");
      end
    end
    if (scl_p && scl_o === 1'b1 && sda_p && sda_now === 1'b0) begin
      mon_log.push_back(S_EV);
      cnt = 0; bidx = 0; tx_mode = 0; rd_pend = 0; slave_pull = 1'b0;
    end else if (scl_p && scl_o === 1'b1 && !sda_p && sda_now === 1'b1) begin
      mon_log.push_back(P_EV);
      cnt = 0; bidx = 0; tx_mode = 0; rd_pend = 0; slave_pull = 1'b0;
    end else if (!scl_p && scl_o === 1'b1) begin
      cnt++;
      if (cnt <= 8) sh = {sh[6:0], sda_now};
      if (cnt == 9) begin
        mon_log.push_back(int'(sh) + (sda_now ? 256 : 0));
        bidx++;
      end
    end else if (scl_p && scl_o === 1'b0) begin
      if (cnt == 8) begin
        if (tx_mode) slave_pull = 1'b0;
        else if (bidx == 0) begin
          slave_pull = (sh[7:1] == SLV);
          rd_pend    = (sh[7:1] == SLV) && sh[0];
        end else slave_pull = 1'b1;
      end else if (cnt == 9) begin
        cnt = 0;
        slave_pull = 1'b0;
        if (tx_mode) tx_mode = 0;
        else if (rd_pend) begin
          rd_pend = 0; tx_mode = 1;
          slave_pull = ~slv_rval[7];
        end
      end else if (cnt >= 1 && cnt <= 7 && tx_mode) begin
        slave_pull = ~slv_rval[3'(7 - cnt)];
      end
    end
    scl_p = (scl_o === 1'b1);
    sda_p = (sda_now === 1'b1);
    i2c_p = i2c_clk_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected bus events for one command, from the protocol rules alone.
  task automatic build_exp(input logic r, input logic [6:0] a, input logic [7:0] rg,
                           input logic [7:0] wd, input logic [7:0] rv, output logic ae);
    exp_q.delete();
    exp_q.push_back(S_EV);
    if (a != SLV) begin
      exp_q.push_back(int'({a, 1'b0}) + 256);
      ae = 1'b1;
    end else begin
      ae = 1'b0;
      exp_q.push_back(int'({a, 1'b0}));
      exp_q.push_back(int'(rg));
      if (!r) exp_q.push_back(int'(wd));
      else begin
        exp_q.push_back(S_EV);
        exp_q.push_back(int'({a, 1'b1}));
        exp_q.push_back(int'(rv) + 256);
        rdata_m = rv;
      end
    end
    exp_q.push_back(P_EV);
  endtask

  task automatic run_txn(input logic r, input logic [6:0] a, input logic [7:0] rg,
                         input logic [7:0] wd, input logic [7:0] rv, input int extra);
    int   base, dbase, cyc;
    logic ae;
    build_exp(r, a, rg, wd, rv, ae);
    slv_rval = rv;
    base  = mon_log.size();
    dbase = done_cnt;
    @(negedge clk_in);
    rw = r; slave_addr = a; reg_addr = rg; wdata = wd; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int k = 0; k < extra; k++) begin
      repeat (50) @(negedge clk_in);
      rw = ~r; slave_addr = SLV; reg_addr = 8'($urandom); wdata = 8'($urandom); start = 1'b1;
      @(negedge clk_in);
      start = 1'b0;
    end
    cyc = 0;
    while (done_cnt == dbase && cyc < 8000) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("done_seen", 32'(done_cnt != dbase), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    repeat (6 * half) @(negedge clk_in);
    chk("done_count", 32'(done_cnt - dbase), 32'd1);
    chk("ack_err", 32'(ack_err), 32'(ae));
    chk("rdata", 32'(rdata), 32'(rdata_m));
    chk("log_len", 32'(mon_log.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      chk("log_item", (base + i < mon_log.size()) ? 32'(mon_log[base + i]) : 32'hFFFF_FFFF,
          32'(exp_q[i]));
  endtask

  initial begin
    logic       r;
    logic [6:0] a;
    logic [7:0] rg, wd, rv;

    repeat (3) @(negedge clk_in);
    chk("rst_scl", 32'(scl_o), 32'd1);
    chk("rst_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ack_err", 32'(ack_err), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    rst_n = 1'b1;

    // clk_config 00 (fast) then 11 (slow); only changed while idle.
    for (int c = 0; c < 2; c++) begin
      half = (c == 0) ? 4 : 10;
      repeat (4 * half) @(negedge clk_in);
      run_txn(1'b0, SLV, 8'h80, 8'h03, 8'h00, 0);
      run_txn(1'b1, SLV, 8'h92, 8'h00, 8'h44, 0);
      run_txn(1'b0, 7'h30, 8'h80, 8'h03, 8'h00, 0);
      run_txn(1'b0, SLV, 8'h10, 8'hA5, 8'h00, 3);
      for (int n = 0; n < 4; n++) begin
        r  = 1'($urandom);
        a  = SLV;
        if ($urandom_range(0, 3) == 0) begin
          a = 7'($urandom);
          if (a == SLV) a = a ^ 7'h01;
        end
        rg = 8'($urandom);
        wd = 8'($urandom);
        rv = 8'($urandom);
        run_txn(r, a, rg, wd, rv, 0);
      end
    end

    // Asynchronous reset in the middle of the address byte.
    @(negedge clk_in);
    rw = 1'b0; slave_addr = SLV; reg_addr = 8'h55; wdata = 8'hAA; start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
    repeat (12 * half) @(negedge clk_in);
    chk("busy_mid_tx", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_scl", 32'(scl_o), 32'd1);
    chk("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rdata_m = 8'h00;
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (8 * half) @(negedge clk_in);
    run_txn(1'b0, SLV, 8'hC3, 8'h5A, 8'h00, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
